output_writeback: RTL and testbench

// Sits directly downstream of top_chip: captures every MEM_BW output word (out/output_valid, no back-pressure) into a FIFO.

---
 rtl/output_writeback.sv | 144 ++++++++++++++
 tb/tb_output_writeback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_writeback.sv
`default_nettype none
// ============================================================================
// Module  : output_writeback
// Brief   : Captures top_chip output words into a FIFO and drains them to the
//           external-memory write port with incrementing word addresses.
// Revision: 1.0 - initial release
// ============================================================================
module output_writeback #(
  parameter int IO_DATA_WIDTH      = 8,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int MEM_BW             = 128,
  parameter int FIFO_DEPTH         = 8,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [MEM_BW-1:0]     out,
  input  logic                  output_valid,
  output logic [MEM_BW-1:0]     mem_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  excess
);

  localparam int c_NB_WORDS = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT *
                              OUTPUT_NB_CHANNELS * IO_DATA_WIDTH / MEM_BW;
  localparam int c_CW = $clog2(c_NB_WORDS + 1);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_FW = c_PW + 1;

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_COLLECT = 2'd1;
  localparam logic [1:0] c_S_DONE    = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [c_CW-1:0]       r_cap_cnt;
  logic [c_CW-1:0]       r_wr_cnt;
  logic                  r_overflow;
  logic                  r_excess;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_FW-1:0]       r_fill;
  logic [MEM_BW-1:0]     r_mem_data [FIFO_DEPTH];
  // Each entry carries its capture index so drops leave address holes.
  logic [c_CW-1:0]       r_mem_idx  [FIFO_DEPTH];

  logic            w_collect;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_cap;
  logic            w_push;
  logic            w_drop;
  logic            w_excess;
  logic [c_CW-1:0] w_wr_cnt_nxt;
  logic [c_CW-1:0] w_head_idx;

  assign w_collect    = (r_state == c_S_COLLECT);
  assign w_empty      = (r_fill == '0);
  assign w_full       = (r_fill == c_FW'(FIFO_DEPTH));
  assign w_pop        = w_collect && !w_empty && mem_wr_ready;
  assign w_cap        = w_collect && output_valid && (r_cap_cnt < c_CW'(c_NB_WORDS));
  assign w_push       = w_cap && (!w_full || w_pop);
  assign w_drop       = w_cap && !w_push;
  assign w_excess     = output_valid &&
                        ((w_collect && (r_cap_cnt == c_CW'(c_NB_WORDS))) ||
                         (r_state == c_S_DONE));
  assign w_wr_cnt_nxt = r_wr_cnt + c_CW'(w_pop) + c_CW'(w_drop);
  assign w_head_idx   = mem_wr_valid ? r_mem_idx[r_rd_ptr] : r_wr_cnt;

  assign mem_wr_valid = w_collect && !w_empty;
  assign mem_wr_data  = r_mem_data[r_rd_ptr];
  assign mem_wr_addr  = r_base + ADDR_WIDTH'(w_head_idx);
  assign busy         = w_collect;
  assign done         = (r_state == c_S_DONE);
  assign overflow     = r_overflow;
  assign excess       = r_excess;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_state    <= c_S_IDLE;
      r_base     <= '0;
      r_cap_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_overflow <= 1'b0;
      r_excess   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fill <= r_fill + c_FW'(w_push) - c_FW'(w_pop);
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            r_state    <= c_S_COLLECT;
            r_base     <= base_addr;
            r_cap_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
            r_excess   <= 1'b0;
          end
        end
        c_S_COLLECT: begin
          if (w_cap)    r_cap_cnt  <= r_cap_cnt + c_CW'(1);
          if (w_drop)   r_overflow <= 1'b1;
          if (w_excess) r_excess   <= 1'b1;
          r_wr_cnt <= w_wr_cnt_nxt;
          // Look ahead so done lands one cycle after the final accept.
          if (w_wr_cnt_nxt == c_CW'(c_NB_WORDS)) r_state <= c_S_DONE;
        end
        c_S_DONE: begin
          if (w_excess) r_excess <= 1'b1;
          r_state <= c_S_IDLE;
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= out;
      r_mem_idx[r_wr_ptr]  <= r_cap_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_writeback
// Brief   : Directed scoreboard bench for output_writeback (4-word layers).
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_writeback;

  localparam int AW = 32;
  localparam int BW = 128;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_in = 1'b1;
  logic          start = 1'b0, start2 = 1'b0;
  logic [AW-1:0] base = '0, base2 = '0;
  logic [BW-1:0] dout = '0, dout2 = '0;
  logic          ovalid = 1'b0, ovalid2 = 1'b0;
  logic          ready = 1'b0, ready2 = 1'b0;

  logic [BW-1:0] wdata, wdata2;
  logic [AW-1:0] waddr, waddr2;
  logic          wvalid, wvalid2, busy, busy2, done, done2, ovf, ovf2, exc, exc2;

  output_writeback #(
    .IO_DATA_WIDTH(8), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .OUTPUT_NB_CHANNELS(16), .MEM_BW(BW), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)
  ) u_dut (
    .clk(clk), .arst_in(arst_in), .start(start), .base_addr(base),
    .out(dout), .output_valid(ovalid), .mem_wr_data(wdata), .mem_wr_addr(waddr),
    .mem_wr_valid(wvalid), .mem_wr_ready(ready), .busy(busy), .done(done),
    .overflow(ovf), .excess(exc)
  );

  output_writeback #(
    .IO_DATA_WIDTH(8), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .OUTPUT_NB_CHANNELS(16), .MEM_BW(BW), .FIFO_DEPTH(2), .ADDR_WIDTH(AW)
  ) u_dut2 (
    .clk(clk), .arst_in(arst_in), .start(start2), .base_addr(base2),
    .out(dout2), .output_valid(ovalid2), .mem_wr_data(wdata2), .mem_wr_addr(waddr2),
    .mem_wr_valid(wvalid2), .mem_wr_ready(ready2), .busy(busy2), .done(done2),
    .overflow(ovf2), .excess(exc2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc1 = 0, acc2 = 0, last_acc1 = 0;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  logic          pv = 1'b0, pr = 1'b0;
  logic [AW-1:0] pa = '0;
  logic [BW-1:0] pd = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop plus hold-stability check for the depth-4 instance.
  always @(negedge clk) begin
    if (!arst_in && wvalid && pv && !pr) begin
      chk("hold_addr", 160'(waddr), 160'(pa));
      chk("hold_data", 160'(wdata), 160'(pd));
    end
    if (!arst_in && wvalid && ready) begin
      chk("write_expected", 160'(q1.size() != 0), 160'(1));
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("wr_addr", 160'(waddr), 160'(e1.a));
        chk("wr_data", 160'(wdata), 160'(e1.d));
      end
      acc1++;
      last_acc1 = cyc;
    end
    pv = wvalid && !arst_in;
    pr = ready;
    pa = waddr;
    pd = wdata;
  end

  always @(negedge clk) begin
    if (!arst_in && wvalid2 && ready2) begin
      chk("write2_expected", 160'(q2.size() != 0), 160'(1));
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("wr2_addr", 160'(waddr2), 160'(e2.a));
        chk("wr2_data", 160'(wdata2), 160'(e2.d));
      end
      acc2++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [AW-1:0] b);
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
    chk("busy_after_start", 160'(busy), 160'(1));
  endtask

  task automatic send(input int idx, input bit expw, input logic [AW-1:0] b);
    logic [BW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    dout   = d;
    ovalid = 1'b1;
    if (expw) q1.push_back({b + 32'(idx), d});
    tick();
    ovalid = 1'b0;
  endtask

  task automatic send2(input int idx, input bit expw, input logic [AW-1:0] b);
    logic [BW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    dout2   = d;
    ovalid2 = 1'b1;
    if (expw) q2.push_back({b + 32'(idx), d});
    tick();
    ovalid2 = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 160'(seen), 160'(1));
    if (seen) chk({tag, "_done_latency"}, 160'(cyc - last_acc1), 160'(1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 160'(busy), 160'(0));
    chk({tag, "_done"}, 160'(done), 160'(0));
    chk({tag, "_overflow"}, 160'(ovf), 160'(0));
    chk({tag, "_excess"}, 160'(exc), 160'(0));
    chk({tag, "_valid"}, 160'(wvalid), 160'(0));
    chk({tag, "_addr"}, 160'(waddr), 160'(0));
    chk({tag, "_data"}, 160'(wdata), 160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    #1;
    check_zero("reset");
    chk("reset_valid2", 160'(wvalid2), 160'(0));
    tick(); tick();
    arst_in = 1'b0;
    tick();

    // Back-to-back capture with the memory always ready.
    ready = 1'b1;
    start_layer(32'h100);
    for (int i = 0; i < 4; i++) send(i, 1'b1, 32'h100);
    wait_done("t1");
    tick();
    chk("t1_queue_empty", 160'(q1.size()), 160'(0));
    chk("t1_overflow", 160'(ovf), 160'(0));
    chk("t1_excess", 160'(exc), 160'(0));
    chk("t1_idle", 160'(busy), 160'(0));

    // Memory stalled while the whole layer arrives.
    ready = 1'b0;
    start_layer(32'h180);
    for (int i = 0; i < 4; i++) send(i, 1'b1, 32'h180);
    tick(); tick();
    chk("t2_overflow", 160'(ovf), 160'(0));
    chk("t2_valid_held", 160'(wvalid), 160'(1));
    chk("t2_addr_head", 160'(waddr), 160'(32'h180));
    ready = 1'b1;
    wait_done("t2");
    tick();
    chk("t2_queue_empty", 160'(q1.size()), 160'(0));

    // Depth-2 FIFO: third word dropped, address hole at base+2.
    ready2 = 1'b0;
    start2 = 1'b1;
    base2  = 32'h400;
    tick();
    start2 = 1'b0;
    send2(0, 1'b1, 32'h400);
    send2(1, 1'b1, 32'h400);
    send2(2, 1'b0, 32'h400);
    chk("t3_overflow", 160'(ovf2), 160'(1));
    ready2 = 1'b1;
    send2(3, 1'b1, 32'h400);
    begin
      bit seen2;
      seen2 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done2) begin
          seen2 = 1'b1;
          break;
        end
      end
      chk("t3_done_seen", 160'(seen2), 160'(1));
    end
    tick();
    chk("t3_queue_empty", 160'(q2.size()), 160'(0));
    chk("t3_write_count", 160'(acc2), 160'(3));
    chk("t3_overflow_sticky", 160'(ovf2), 160'(1));

    // Six words into a four-word layer.
    ready = 1'b1;
    start_layer(32'h500);
    fork
      begin
        for (int i = 0; i < 6; i++) send(i, i < 4, 32'h500);
      end
      wait_done("t4");
    join
    tick();
    chk("t4_queue_empty", 160'(q1.size()), 160'(0));
    chk("t4_excess", 160'(exc), 160'(1));
    chk("t4_overflow", 160'(ovf), 160'(0));
    send(0, 1'b0, 32'h0);
    tick(); tick();
    chk("t4_excess_sticky", 160'(exc), 160'(1));
    chk("t4_idle_no_write", 160'(wvalid), 160'(0));

    // Address wrap across 2^32.
    start_layer(32'hFFFF_FFFE);
    chk("t5_excess_cleared", 160'(exc), 160'(0));
    for (int i = 0; i < 4; i++) send(i, 1'b1, 32'hFFFF_FFFE);
    wait_done("t5");
    tick();
    chk("t5_queue_empty", 160'(q1.size()), 160'(0));

    // Asynchronous reset in the middle of a layer.
    ready = 1'b0;
    start_layer(32'h300);
    for (int i = 0; i < 4; i++) send(i, 1'b1, 32'h300);
    a0 = acc1;
    ready = 1'b1;
    tick(); tick();
    ready = 1'b0;
    chk("t6_two_writes", 160'(acc1 - a0), 160'(2));
    chk("t6_busy_before_reset", 160'(busy), 160'(1));
    #2;
    arst_in = 1'b1;
    #1;
    check_zero("t6_async");
    q1.delete();
    tick(); tick();
    arst_in = 1'b0;
    tick();
    ready = 1'b1;
    start_layer(32'h200);
    for (int i = 0; i < 4; i++) send(i, 1'b1, 32'h200);
    wait_done("t6");
    tick();
    chk("t6_queue_empty", 160'(q1.size()), 160'(0));
    chk("t6_overflow", 160'(ovf), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
